// File: rtl/if_stage_pipe.sv
// rtl/if_stage_pipe.sv - instruction fetch stage: PC register, IF/ID register, stall/redirect, perf counters
module if_stage_pipe #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic               ifid_valid,
    output logic               misalign,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;

    assign imem_addr = pc;
    assign pc_plus   = pc + STEP;

    // Priority: reset > redirect > stall > advance; redirect overrides a concurrent stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc           <= RESET_PC;
            ifid_instr   <= NOP_WORD;
            ifid_pc_next <= '0;
            ifid_valid   <= 1'b0;
            misalign     <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else if (redirect) begin
            pc           <= redirect_pc & ~ALIGN_MASK;
            ifid_instr   <= NOP_WORD;
            ifid_pc_next <= '0;
            ifid_valid   <= 1'b0;
            if (|(redirect_pc & ALIGN_MASK))
                misalign <= 1'b1;
            if (flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (stall) begin
            if (stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            pc           <= pc_plus;
            ifid_instr   <= imem_data;
            ifid_pc_next <= pc_plus;
            ifid_valid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_pipe.sv
// tb/tb_if_stage_pipe.sv - scoreboard bench for if_stage_pipe (default and narrow configurations)
module tb_if_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: default parameters
    logic        a_reset, a_stall, a_redirect;
    logic [31:0] a_rpc, a_idata, a_addr, a_instr, a_pcn;
    logic        a_valid, a_mis;
    logic [15:0] a_sc, a_fc;

    // instance b: ADDR_W=8, RESET_PC=0xF8, CNT_W=3
    logic        b_reset, b_stall, b_redirect;
    logic [7:0]  b_rpc, b_addr, b_pcn;
    logic [31:0] b_idata, b_instr;
    logic        b_valid, b_mis;
    logic [2:0]  b_sc, b_fc;

    assign a_idata = a_addr;
    assign b_idata = {24'h0, b_addr};

    if_stage_pipe dut_a (
        .clk(clk), .reset(a_reset), .stall(a_stall), .redirect(a_redirect),
        .redirect_pc(a_rpc), .imem_data(a_idata), .imem_addr(a_addr),
        .ifid_instr(a_instr), .ifid_pc_next(a_pcn), .ifid_valid(a_valid),
        .misalign(a_mis), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    if_stage_pipe #(.ADDR_W(8), .RESET_PC(8'hF8), .CNT_W(3)) dut_b (
        .clk(clk), .reset(b_reset), .stall(b_stall), .redirect(b_redirect),
        .redirect_pc(b_rpc), .imem_data(b_idata), .imem_addr(b_addr),
        .ifid_instr(b_instr), .ifid_pc_next(b_pcn), .ifid_valid(b_valid),
        .misalign(b_mis), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    typedef struct {
        logic [31:0] pc, instr, pcn;
        logic        v, mis;
        logic [15:0] sc, fc;
    } st_t;

    int  n_chk  = 0;
    int  n_pass = 0;
    st_t ma, mb;
    st_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic st_t model(st_t s, bit rn, bit st, bit rd, logic [31:0] rpc,
                                  logic [31:0] amask, logic [15:0] cmax, logic [31:0] rpc0);
        st_t n = s;
        if (!rn) begin
            n.pc = rpc0; n.instr = 0; n.pcn = 0; n.v = 0; n.mis = 0; n.sc = 0; n.fc = 0;
        end else if (rd) begin
            n.pc = rpc & 32'hFFFF_FFFC & amask;
            n.instr = 0; n.pcn = 0; n.v = 0;
            if (rpc[1:0] != 2'b00) n.mis = 1;
            if (s.fc != cmax) n.fc = s.fc + 1;
        end else if (st) begin
            if (s.sc != cmax) n.sc = s.sc + 1;
        end else begin
            n.pc = (s.pc + 32'd4) & amask;
            n.instr = s.pc;
            n.pcn = (s.pc + 32'd4) & amask;
            n.v = 1;
        end
        return n;
    endfunction

    // sel=0 drives instance a, sel=1 drives instance b; the idle instance is held in reset
    task automatic step(input bit sel, input bit rn, input bit st, input bit rd, input logic [31:0] rpc);
        st_t e, g;
        string p;
        if (!sel) begin
            a_reset = rn; a_stall = st; a_redirect = rd; a_rpc = rpc;
            b_reset = 0; b_stall = 0; b_redirect = 0; b_rpc = 0;
            ma = model(ma, rn, st, rd, rpc, 32'hFFFF_FFFF, 16'hFFFF, 32'h0);
            exp_q.push_back(ma);
        end else begin
            b_reset = rn; b_stall = st; b_redirect = rd; b_rpc = rpc[7:0];
            a_reset = 0; a_stall = 0; a_redirect = 0; a_rpc = 0;
            mb = model(mb, rn, st, rd, {24'h0, rpc[7:0]}, 32'hFF, 16'h7, 32'hF8);
            exp_q.push_back(mb);
        end
        @(posedge clk);
        #1;
        if (!sel) begin
            g.pc = a_addr; g.instr = a_instr; g.pcn = a_pcn; g.v = a_valid;
            g.mis = a_mis; g.sc = a_sc; g.fc = a_fc; p = "a";
        end else begin
            g.pc = {24'h0, b_addr}; g.instr = b_instr; g.pcn = {24'h0, b_pcn}; g.v = b_valid;
            g.mis = b_mis; g.sc = {13'h0, b_sc}; g.fc = {13'h0, b_fc}; p = "b";
        end
        e = exp_q.pop_front();
        check({p, "_addr"},  g.pc,    e.pc);
        check({p, "_instr"}, g.instr, e.instr);
        check({p, "_pcn"},   g.pcn,   e.pcn);
        check({p, "_valid"}, {31'h0, g.v},   {31'h0, e.v});
        check({p, "_mis"},   {31'h0, g.mis}, {31'h0, e.mis});
        check({p, "_scnt"},  {16'h0, g.sc},  {16'h0, e.sc});
        check({p, "_fcnt"},  {16'h0, g.fc},  {16'h0, e.fc});
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        a_reset = 0; a_stall = 0; a_redirect = 0; a_rpc = 0;
        b_reset = 0; b_stall = 0; b_redirect = 0; b_rpc = 0;

        // reset and first fetches
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t1_reset_addr",  a_addr, 32'h0);
        check("t1_reset_valid", {31'h0, a_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        check("t1_instr0", a_instr, 32'h0);
        check("t1_pcn0",   a_pcn,   32'h4);
        step(0, 1, 0, 0, 0);
        check("t1_addr8",  a_addr,  32'h8);
        check("t1_instr4", a_instr, 32'h4);

        // advance to 0x10, stall 3
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        check("t2_addr", a_addr, 32'h10);
        check("t2_scnt", {16'h0, a_sc}, 32'd3);

        // advance to 0x20, redirect to 0x100
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        check("t3_pre_addr", a_addr, 32'h20);
        step(0, 1, 0, 1, 32'h100);
        check("t3_addr",  a_addr, 32'h100);
        check("t3_fcnt",  {16'h0, a_fc}, 32'd1);
        step(0, 1, 0, 0, 0);
        check("t3_instr", a_instr, 32'h100);

        // stall + misaligned redirect, then sticky misalign
        step(0, 1, 1, 1, 32'h203);
        check("t4_addr", a_addr, 32'h200);
        check("t4_mis",  {31'h0, a_mis}, 32'h1);
        check("t4_scnt", {16'h0, a_sc}, 32'd3);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        check("t4_mis_sticky", {31'h0, a_mis}, 32'h1);

        // random mix on instance a
        for (int i = 0; i < 60; i++)
            step(0, ($urandom_range(0, 19) != 0), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, $urandom);

        // narrow instance: PC wrap
        step(1, 0, 0, 0, 0);
        check("t5_reset_addr", {24'h0, b_addr}, 32'hF8);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("t5_wrap_addr", {24'h0, b_addr}, 32'h00);
        check("t5_wrap_pcn",  {24'h0, b_pcn},  32'h00);
        check("t5_wrap_instr", b_instr, 32'hFC);

        // counter saturation, then reset mid-stall
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);
        check("t6_sat", {29'h0, b_sc}, 32'd7);
        step(1, 0, 1, 0, 0);
        check("t6_clr", {29'h0, b_sc}, 32'd0);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 1, 32'h13);
        check("t6_fsat", {29'h0, b_fc}, 32'd7);
        step(1, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
